instruction_fetch_queue: RTL
============================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port pc_in  input  32  fetch address from the fetch unit.
REQ-005 SHALL have port pc_valid  input  1  pc_in carries a fetch request.
REQ-006 SHALL have port pc_ready  output  1  queue accepts a request this cycle.
REQ-007 SHALL have port flush  input  1  taken branch/jump; discard all queued and in-flight fetches.
REQ-008 SHALL have port imem_en  output  1  instruction memory read strobe.
REQ-009 SHALL have port imem_addr  output  32  instruction memory read address.
REQ-010 SHALL have port imem_rdata  input  32  read data, valid exactly 1 cycle after imem_en.
REQ-011 SHALL have port instr_out  output  32  head-entry instruction to decode.
REQ-012 SHALL have port instr_pc  output  32  head-entry PC.
REQ-013 SHALL have port instr_misaligned  output  1  head entry fetched from a PC with pc[1:0] != 0.
REQ-014 SHALL have port instr_valid  output  1  head entry present.
REQ-015 SHALL have port instr_ready  input  1  decode consumes the head entry this cycle.
REQ-016 SHALL have port occupancy  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-017 SHALL accept a request when pc_valid && pc_ready; acceptance = accept cycle.
REQ-018 SHALL drive pc_ready = !flush && (occupancy + inflight) < DEPTH; inflight is a 1-bit register; no credit from a same-cycle pop.
REQ-019 SHALL, in the accept cycle, drive imem_en=1 and imem_addr=pc_in combinationally; otherwise imem_en=0 and imem_addr holds its last value.
REQ-020 SHALL set inflight on accept and, in the following cycle, write {PC, imem_rdata, misaligned} at the tail pointer and clear inflight unless a new accept occurs.
REQ-021 SHALL sustain one accept per cycle back-to-back while pc_ready is high.
REQ-022 SHALL present an entry at the outputs 2 cycles after its accept cycle (accept at N, instr_valid at N+2 into an empty queue).
REQ-023 SHALL drive instr_valid = (occupancy != 0); instr_out, instr_pc and instr_misaligned come from the head pointer and are stable while instr_valid && !instr_ready.
REQ-024 SHALL pop on instr_valid && instr_ready; simultaneous write and pop leave occupancy unchanged.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH.
REQ-026 SHALL, on flush=1, clear occupancy, head, tail and inflight at the next edge, drop the imem_rdata of any in-flight fetch, force imem_en=0, and ignore pops and pushes in that cycle.
REQ-027 SHALL accept a new request in the cycle after flush deasserts.
REQ-028 SHALL treat instr_ready while instr_valid=0 as a no-op.

Reset
REQ-029 SHALL, on reset=0 at a clock edge, clear occupancy, head, tail and inflight; the following cycle has instr_valid=0, imem_en=0, imem_addr=0, pc_ready=0 while reset=0.
REQ-030 SHALL give reset priority over flush, accept and pop, including mid-operation with a fetch in flight; returning data is discarded.
REQ-031 SHALL not require storage array contents to be reset; outputs for invalid entries are don't-care except instr_valid.

Structure
REQ-032 SHALL place the DEPTH default, the entry typedef {pc[31:0], instr[31:0], misaligned}, and the NOP constant 32'h00000013 (for bench use) in shared package ifq_pkg.
REQ-033 SHALL implement entry storage and pointers in one sub-module, ifq_storage; handshake, inflight and memory interface in the top.

Verification
REQ-034 SHALL cover: reset, then pc_in=0x0,0x4,0x8,0xC back-to-back, instr_ready=1 -> instr_valid from cycle 2, instr_pc 0x0,0x4,0x8,0xC consecutively.
REQ-035 SHALL cover: instr_ready=0, 6 requests offered -> exactly 4 accepted, pc_ready=0 at occupancy+inflight=4, occupancy=4.
REQ-036 SHALL cover: flush asserted while inflight=1 and occupancy=3 -> next cycle occupancy=0, instr_valid=0, stale rdata never appears; next accept 0x100 is output first.
REQ-037 SHALL cover: full queue, instr_ready held at 1 with pc_valid=1 -> one push and one pop per cycle after refill, no lost or duplicated PC over 10 cycles, pointers wrap.
REQ-038 SHALL cover: pc_in=0x6 -> instr_misaligned=1 with instr_pc=0x6; reset=0 mid-stream -> all outputs as REQ-029 next cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: default depth,
// the stored entry layout and the canonical NOP encoding.
package ifq_pkg;

    localparam int IFQ_DEPTH = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Circular entry buffer for the fetch queue: head/tail pointers,
// occupancy count and the entry array. Pointers wrap modulo DEPTH.
module ifq_storage
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  entry_t                   i_wdata,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;

    // A clear cycle ignores both pushes and pops; pops of an empty buffer are dropped.
    assign w_push = i_push && !i_clear;
    assign w_pop  = i_pop && !i_clear && (r_count != '0);

    // Pointer and occupancy bookkeeping; reset and clear both empty the buffer.
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry array holds data only; stale slots are masked by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_wdata;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: accepts fetch PCs, issues single-cycle-latency
// instruction memory reads and buffers {pc, instr, misaligned} for decode.
// One fetch may be in flight; its data is written one cycle after accept.
module instruction_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_in,
    input  logic                     pc_valid,
    output logic                     pc_ready,
    input  logic                     flush,
    output logic                     imem_en,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic [31:0]              instr_out,
    output logic [31:0]              instr_pc,
    output logic                     instr_misaligned,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   r_imem_addr;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_level;
    logic          w_ready;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    entry_t        w_wdata;
    entry_t        w_head;

    // Space check counts the in-flight fetch but gives no credit for a same-cycle pop.
    assign w_level  = w_count + CW'(r_inflight);
    assign w_ready  = reset && !flush && (w_level < CW'(DEPTH));
    assign w_accept = pc_valid && w_ready;

    // Returning data lands in the buffer; flush is applied inside storage as a clear.
    assign w_push   = reset && r_inflight;
    assign w_pop    = reset && instr_valid && instr_ready;

    assign w_wdata.pc         = r_inflight_pc;
    assign w_wdata.instr      = imem_rdata;
    assign w_wdata.misaligned = (r_inflight_pc[1:0] != 2'b00);

    ifq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // In-flight flag and held read address; accept is already blocked by flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inflight  <= 1'b0;
            r_imem_addr <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) r_imem_addr <= pc_in;
        end
    end

    // PC of the fetch in flight, paired with its read data next cycle.
    always_ff @(posedge clk) begin
        if (w_accept) r_inflight_pc <= pc_in;
    end

    assign pc_ready         = w_ready;
    assign imem_en          = w_accept;
    assign imem_addr        = w_accept ? pc_in : r_imem_addr;
    assign instr_valid      = (w_count != '0);
    assign instr_out        = w_head.instr;
    assign instr_pc         = w_head.pc;
    assign instr_misaligned = w_head.misaligned;
    assign occupancy        = w_count;

endmodule
